// File: rtl/intt_butterfly_if.sv
// intt_butterfly_if
//   Bundles the operand side and the result side of the inverse-NTT
//   Cooley-Tukey butterfly.
//   master : drives q, in_valid, in_halve, A, B, W; receives out_valid, E, O
//   slave  : the butterfly itself
//   DW     : coefficient / modulus width in bits
interface intt_butterfly_if #(
    parameter int DW = 16
);
    logic [DW-1:0] q;
    logic          in_valid;
    logic          in_halve;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic [DW-1:0] W;
    logic          out_valid;
    logic [DW-1:0] E;
    logic [DW-1:0] O;

    modport master (
        output q, in_valid, in_halve, A, B, W,
        input  out_valid, E, O
    );

    modport slave (
        input  q, in_valid, in_halve, A, B, W,
        output out_valid, E, O
    );
endinterface

// File: rtl/intt_butterfly.sv
// intt_butterfly
//   Fully pipelined Cooley-Tukey butterfly for the inverse NTT:
//     t = B*W mod q,  E = (A + t) [/2] mod q,  O = (A - t) [/2] mod q
//   One butterfly per cycle, latency MUL_LAT + 2 cycles, no backpressure.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high; clears input stage, A/valid/halve
//             delay lines and outputs (multiplier pipe is not reset, its
//             contents are qualified by the valid line)
//     bus   : intt_butterfly_if.slave (q, in_valid, in_halve, A, B, W ->
//             out_valid, E, O)
//   Parameters:
//     DW      : coefficient width; q must be odd and below 2^(DW-1)
//     MUL_LAT : modular multiplier latency in cycles, must be >= 2
module intt_butterfly #(
    parameter int DW      = 16,
    parameter int MUL_LAT = 4
) (
    input logic             clk,
    input logic             reset,
    intt_butterfly_if.slave bus
);

    // ------------------------------------------------------------------
    // Stage 0: input registers
    // ------------------------------------------------------------------
    logic [DW-1:0] a_in_d, a_in_q;
    logic [DW-1:0] b_in_d, b_in_q;
    logic [DW-1:0] w_in_d, w_in_q;
    logic          vld_in_d, vld_in_q;
    logic          hlv_in_d, hlv_in_q;

    always_comb begin
        a_in_d   = bus.A;
        b_in_d   = bus.B;
        w_in_d   = bus.W;
        vld_in_d = bus.in_valid;
        hlv_in_d = bus.in_halve;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_in_q   <= '0;
            b_in_q   <= '0;
            w_in_q   <= '0;
            vld_in_q <= 1'b0;
            hlv_in_q <= 1'b0;
        end else begin
            a_in_q   <= a_in_d;
            b_in_q   <= b_in_d;
            w_in_q   <= w_in_d;
            vld_in_q <= vld_in_d;
            hlv_in_q <= hlv_in_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: modular multiplier, MUL_LAT cycles
    //   cycle 1       : raw product register
    //   cycle 2       : bit-serial restoring reduction mod q, registered
    //   cycles 3..LAT : retiming slack for the reduction
    // ------------------------------------------------------------------
    logic [2*DW-1:0] prod_d, prod_q;
    logic [DW:0]     rem;
    logic [DW-1:0]   red;
    logic [DW-1:0]   t_pipe_d [MUL_LAT-1];
    logic [DW-1:0]   t_pipe_q [MUL_LAT-1];

    always_comb begin
        prod_d = b_in_q * w_in_q;
    end

    // Remainder stays below q < 2^(DW-1), so one shifted-in bit never
    // overflows DW+1 bits and one conditional subtract per bit suffices.
    always_comb begin
        rem = '0;
        for (int unsigned i = 0; i < 2 * DW; i++) begin
            rem = {rem[DW-1:0], prod_q[2*DW-1-i]};
            if (rem >= {1'b0, bus.q}) begin
                rem = rem - {1'b0, bus.q};
            end
        end
        red = DW'(rem);
    end

    always_comb begin
        t_pipe_d[0] = red;
        for (int unsigned i = 1; i < MUL_LAT - 1; i++) begin
            t_pipe_d[i] = t_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        prod_q   <= prod_d;
        t_pipe_q <= t_pipe_d;
    end

    // ------------------------------------------------------------------
    // A / valid / halve delay lines, MUL_LAT deep to stay aligned with t
    // ------------------------------------------------------------------
    logic [DW-1:0]      a_dly_d [MUL_LAT];
    logic [DW-1:0]      a_dly_q [MUL_LAT];
    logic [MUL_LAT-1:0] vld_dly_d, vld_dly_q;
    logic [MUL_LAT-1:0] hlv_dly_d, hlv_dly_q;

    always_comb begin
        a_dly_d[0]   = a_in_q;
        vld_dly_d[0] = vld_in_q;
        hlv_dly_d[0] = hlv_in_q;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            a_dly_d[i]   = a_dly_q[i-1];
            vld_dly_d[i] = vld_dly_q[i-1];
            hlv_dly_d[i] = hlv_dly_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                a_dly_q[i] <= '0;
            end
            vld_dly_q <= '0;
            hlv_dly_q <= '0;
        end else begin
            a_dly_q   <= a_dly_d;
            vld_dly_q <= vld_dly_d;
            hlv_dly_q <= hlv_dly_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: modular add / subtract, optional halving, output register
    // ------------------------------------------------------------------
    // x/2 mod q: an odd x is made even by adding the (odd) modulus first.
    function automatic logic [DW:0] halve_mod(input logic [DW:0] x,
                                              input logic [DW:0] m);
        logic [DW:0] y;
        y = x[0] ? (x + m) : x;
        return y >> 1;
    endfunction

    logic [DW:0]   q_ext;
    logic [DW:0]   ad_ext;
    logic [DW:0]   t_ext;
    logic [DW:0]   s_raw, s_mod;
    logic [DW:0]   d_raw, d_mod;
    logic          halve_d;
    logic [DW-1:0] e_d, e_q;
    logic [DW-1:0] o_d, o_q;
    logic          out_vld_d, out_vld_q;

    always_comb begin
        q_ext   = {1'b0, bus.q};
        ad_ext  = {1'b0, a_dly_q[MUL_LAT-1]};
        t_ext   = {1'b0, t_pipe_q[MUL_LAT-2]};
        halve_d = hlv_dly_q[MUL_LAT-1];

        s_raw = ad_ext + t_ext;
        s_mod = (s_raw >= q_ext) ? (s_raw - q_ext) : s_raw;

        // Bit DW is the borrow of the DW+1-bit difference.
        d_raw = ad_ext - t_ext;
        d_mod = d_raw[DW] ? (d_raw + q_ext) : d_raw;

        e_d       = DW'(halve_d ? halve_mod(s_mod, q_ext) : s_mod);
        o_d       = DW'(halve_d ? halve_mod(d_mod, q_ext) : d_mod);
        out_vld_d = vld_dly_q[MUL_LAT-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= '0;
            o_q       <= '0;
            out_vld_q <= 1'b0;
        end else begin
            e_q       <= e_d;
            o_q       <= o_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign bus.E         = e_q;
    assign bus.O         = o_q;
    assign bus.out_valid = out_vld_q;

endmodule

// File: doc/intt_butterfly.md
Name: intt_butterfly

Overview:
Cooley-Tukey butterfly for the inverse-NTT datapath. It is the dual of the forward Gentleman-Sande butterfly, which does add/sub first and then multiplies. This block multiplies first (t = B*W mod q), then produces E = A+t and O = A-t mod q, with optional halving for the INTT 1/2 scaling per stage. It is fully pipelined, accepts one butterfly per cycle, carries a valid bit alongside the data, and sits in the INTT stage array fed by the coefficient BRAM read logic.

Parameters:
DW, `DATA_SIZE_ARB, coefficient/modulus width in bits
MUL_LAT, `INTMUL_DELAY+`MODRED_DELAY, latency of the ModMult instance in cycles

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
q  input  DW  modulus, odd, q < 2^(DW-1); held static during operation
in_valid  input  1  A/B/W/halve valid this cycle
in_halve  input  1  1 = divide both outputs by 2 mod q
A  input  DW  top operand, 0 <= A < q
B  input  DW  bottom operand, 0 <= B < q
W  input  DW  twiddle (inverse root power), 0 <= W < q
out_valid  output  1  E/O valid
E  output  DW  (A + B*W) [/2] mod q
O  output  DW  (A - B*W) [/2] mod q

Behaviour:
- Reset value of every output is 0: out_valid = 0, E = 0, O = 0.
- Reset clears the input registers, the valid/halve delay line and the A delay line. The clk and reset port names match the rest of the codebase.
- Stage 0 (input register, 1 cycle): latch A, B, W, in_valid, in_halve. Registers load every cycle; there is no enable and no backpressure.
- Stage 1 (MUL_LAT cycles): ModMult(Breg, Wreg, q) produces t.
  - Areg, valid and halve are delayed through ShiftReg chains of depth MUL_LAT so they stay aligned with t.
- Stage 2 (1 registered cycle), computed combinationally then registered:
  - s = Ad + t on DW+1 bits; if s >= q then s - q, else s.
  - d = Ad - t on DW+1 bits; if it borrows then d + q, else d.
  - Halving, applied when halve_d = 1: h(x) = x>>1 if x is even, else (x+q)>>1. Compute on DW+1 bits. The result is always < q.
  - E <= halve_d ? h(s) : s;  O <= halve_d ? h(d) : d;  out_valid <= valid_d.
- Total latency is MUL_LAT + 2 cycles from the in_valid edge to the out_valid edge. Throughput is 1 per cycle.
- Data registers update even when the valid bit is 0. Consumers qualify data with out_valid only.
- Boundaries:
  - t = 0 gives E = O = A.
  - A = 0 and t > 0 gives O = q - t.
  - s = q wraps to 0.
  - Back-to-back valids with alternating in_halve are each processed independently.
- Reset mid-operation: all in-flight valids are dropped, and out_valid stays 0 until the first post-reset input emerges MUL_LAT + 2 cycles after it is presented.
  - ModMult internal state is don't-care because out_valid gates it.
- q must not change while any valid is in flight; if it does, the result is undefined.

Test Plan:
1. q=7681, A=5, B=3, W=2, halve=0 -> after MUL_LAT+2 cycles out_valid=1, E=11, O=7680.
2. Same inputs with halve=1 -> E=3846, O=3840.
3. q=7681, A=7680, B=1, W=1, halve=0 -> E=0, O=7679. With halve=1 -> E=0, O=7680.
4. Stream 64 back-to-back random valid vectors with random halve, plus some in_valid=0 bubbles -> outputs match a golden model in order, latency is exactly MUL_LAT+2, and bubbles appear as out_valid=0 at matching positions.
5. Assert reset asynchronously mid-stream, between clock edges, with 5 items in flight -> E, O and out_valid go to 0 immediately. No stale valid appears afterwards, and the first post-reset item is correct.
6. B=0 or W=0 with A=1234, q=12289 -> E=O=1234. With halve=1 -> E=O=617.
